// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data-port responder: MMIO map, region tags, byte-lane merge.
package data_sram_responder_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hbfaf;

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_SWITCH = 16'hf010;
  localparam logic [15:0] OFF_TIMER  = 16'he000;

  // Offsets are compared as word indices since addr[1:0] never participates in decode.
  localparam logic [13:0] LED_WOFF    = OFF_LED[15:2];
  localparam logic [13:0] SWITCH_WOFF = OFF_SWITCH[15:2];
  localparam logic [13:0] TIMER_WOFF  = OFF_TIMER[15:2];

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_MMIO
  } region_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-style data port between the CPU core (master) and the responder (slave).
interface data_sram_responder_if;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/data_sram_responder_sram_word_ram.sv
// Single-port 32-bit word RAM with byte enables and a registered read port (no reset on contents).
module sram_word_ram #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (|we_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU data port: word RAM plus LED/switch/timer MMIO window, 1-cycle read latency.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  sram,
  output logic [LED_W-1:0]      led,
  input  logic [SW_W-1:0]       switch_in
);

  logic              is_mmio;
  logic [13:0]       off_w;
  logic              req_rd;
  logic              req_wr;
  logic              wr_led;
  logic              wr_timer;

  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  region_e           region_q, region_d;
  logic [31:0]       mmio_rdata_q, mmio_rdata_d;

  logic [31:0]       led_ext, sw_ext, mmio_rd;
  logic [31:0]       ram_rdata;
  logic              unused_addr_bits;

  assign is_mmio  = (sram.sram_addr[31:16] == MMIO_BASE);
  assign off_w    = sram.sram_addr[15:2];
  assign req_rd   = sram.sram_en && (sram.sram_we == 4'b0000);
  assign req_wr   = sram.sram_en && (sram.sram_we != 4'b0000);
  assign wr_led   = req_wr && is_mmio && (off_w == LED_WOFF);
  assign wr_timer = req_wr && is_mmio && (off_w == TIMER_WOFF);

  assign unused_addr_bits = ^sram.sram_addr[1:0];

  sram_word_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (sram.sram_en && !is_mmio),
    .we_i    (sram.sram_we),
    .addr_i  (sram.sram_addr[RAM_AW+1:2]),
    .wdata_i (sram.sram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led_q;
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_sync_q;

    mmio_rd = '0;
    case (off_w)
      LED_WOFF:    mmio_rd = led_ext;
      SWITCH_WOFF: mmio_rd = sw_ext;
      TIMER_WOFF:  mmio_rd = timer_q;
      default:     mmio_rd = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (wr_led) begin
      for (int unsigned b = 0; b < LED_W; b++) begin
        if (sram.sram_we[b/8]) led_d[b] = sram.sram_wdata[b];
      end
    end

    // A timer write replaces that cycle's increment; unwritten lanes keep the current count.
    timer_d = timer_q + 32'd1;
    if (wr_timer) timer_d = byte_merge(timer_q, sram.sram_wdata, sram.sram_we);

    region_d     = region_q;
    mmio_rdata_d = mmio_rdata_q;
    if (req_rd) begin
      region_d     = is_mmio ? REG_MMIO : REG_RAM;
      mmio_rdata_d = mmio_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q        <= '0;
      timer_q      <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      region_q     <= REG_NONE;
      mmio_rdata_q <= '0;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      sw_meta_q    <= switch_in;
      sw_sync_q    <= sw_meta_q;
      region_q     <= region_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  // Region tag is registered with the request so it lines up with the RAM's registered output.
  always_comb begin
    sram.sram_rdata = '0;
    case (region_q)
      REG_RAM:  sram.sram_rdata = ram_rdata;
      REG_MMIO: sram.sram_rdata = mmio_rdata_q;
      default:  sram.sram_rdata = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed plus randomized bench for data_sram_responder against a behavioural memory-map model.
module tb_data_sram_responder;

  localparam int unsigned RAM_AW    = 14;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [15:0] led;
  logic [7:0]  switch_in = 8'h00;

  data_sram_responder_if bus ();

  data_sram_responder #(
    .RAM_AW    (RAM_AW),
    .MMIO_BASE (16'hbfaf),
    .LED_W     (16),
    .SW_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sram      (bus),
    .led       (led),
    .switch_in (switch_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram_m [int unsigned];
  logic [15:0] m_led   = 16'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_rd    = 32'h0;
  logic [7:0]  m_sw    = 8'h0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return a[31:16] == 16'hbfaf;
  endfunction

  function automatic int unsigned ram_idx(input logic [31:0] a);
    return (a >> 2) % RAM_WORDS;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [15:0] off;
    if (in_mmio(a)) begin
      off = a[15:0] & 16'hfffc;
      case (off)
        16'hf000: return {16'h0, m_led};
        16'hf010: return {24'h0, m_sw};
        16'he000: return m_timer;
        default:  return 32'h0;
      endcase
    end
    return ram_m[ram_idx(a)];
  endfunction

  task automatic model_edge(input logic en, input logic [3:0] we, input logic [31:0] a,
                            input logic [31:0] wd);
    bit          timer_written;
    logic [15:0] off;
    logic [31:0] t;
    int unsigned k;
    timer_written = 0;
    if (en && we == 4'h0) begin
      m_rd = model_read(a);
    end else if (en) begin
      if (in_mmio(a)) begin
        off = a[15:0] & 16'hfffc;
        if (off == 16'hf000) begin
          t = merge({16'h0, m_led}, wd, we);
          m_led = t[15:0];
        end else if (off == 16'he000) begin
          m_timer = merge(m_timer, wd, we);
          timer_written = 1;
        end
      end else begin
        k = ram_idx(a);
        t = ram_m.exists(k) ? ram_m[k] : 32'h0;
        ram_m[k] = merge(t, wd, we);
      end
    end
    if (!timer_written) m_timer = m_timer + 32'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one request, models the edge, checks at the next negedge.
  task automatic cyc(input string tag, input logic en, input logic [3:0] we,
                     input logic [31:0] a, input logic [31:0] wd);
    bus.sram_en    = en;
    bus.sram_we    = we;
    bus.sram_addr  = a;
    bus.sram_wdata = wd;
    @(posedge clk);
    model_edge(en, we, a, wd);
    @(negedge clk);
    check({tag, "_rdata"}, bus.sram_rdata, m_rd);
    check({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [13:0] pool [8];
  logic [15:0] up;
  logic [31:0] a, wd;
  logic [3:0]  we;
  int unsigned op, p;
  logic [15:0] mmio_offs [5];

  initial begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'h0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    mmio_offs[0] = 16'hf000; mmio_offs[1] = 16'hf010; mmio_offs[2] = 16'he000;
    mmio_offs[3] = 16'hf0f0; mmio_offs[4] = 16'he004;

    #1;
    check("reset_rdata", bus.sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    cyc("ram_wr", 1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    cyc("ram_rd", 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("ram_rd_const", bus.sram_rdata, 32'h1234_5678);

    cyc("lane_wr", 1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
    check("lane_wr_hold", bus.sram_rdata, 32'h1234_5678);
    cyc("lane_rd", 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("lane_rd_const", bus.sram_rdata, 32'h12BB_56DD);

    cyc("wrap_wr", 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D);
    cyc("wrap_rd", 1'b1, 4'h0, 32'h4 << RAM_AW, 32'h0);
    check("wrap_rd_const", bus.sram_rdata, 32'hCAFE_F00D);

    cyc("led_wr", 1'b1, 4'hF, 32'hbfaf_f000, 32'hFFFF_1234);
    check("led_const", {16'h0, led}, 32'h0000_1234);
    cyc("led_rd", 1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
    check("led_rd_const", bus.sram_rdata, 32'h0000_1234);

    switch_in = 8'h5A;
    m_sw      = 8'h5A;
    idle("sw_sync1");
    idle("sw_sync2");
    cyc("sw_rd", 1'b1, 4'h0, 32'hbfaf_f010, 32'h0);
    check("sw_rd_const", bus.sram_rdata, 32'h0000_005A);
    cyc("sw_wr_ign", 1'b1, 4'hF, 32'hbfaf_f010, 32'hFFFF_FFFF);
    cyc("sw_rd2", 1'b1, 4'h0, 32'hbfaf_f010, 32'h0);
    check("sw_rd2_const", bus.sram_rdata, 32'h0000_005A);

    cyc("unmapped_rd", 1'b1, 4'h0, 32'hbfaf_f0f0, 32'h0);
    check("unmapped_const", bus.sram_rdata, 32'h0);

    cyc("tmr_wr", 1'b1, 4'hF, 32'hbfaf_e000, 32'hFFFF_FFFE);
    cyc("tmr_rd0", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("tmr_rd0_const", bus.sram_rdata, 32'hFFFF_FFFE);
    cyc("tmr_rd1", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("tmr_rd1_const", bus.sram_rdata, 32'hFFFF_FFFF);
    cyc("tmr_rd2", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("tmr_rd2_const", bus.sram_rdata, 32'h0000_0000);
    idle("tmr_hold1");
    check("tmr_hold_const", bus.sram_rdata, 32'h0000_0000);
    cyc("en0_noise", 1'b0, 4'hF, 32'hbfaf_f000, 32'h0000_BEEF);
    check("en0_led_const", {16'h0, led}, 32'h0000_1234);

    // Reset asserted while a LED read is being returned.
    bus.sram_en   = 1'b1;
    bus.sram_we   = 4'h0;
    bus.sram_addr = 32'hbfaf_f000;
    @(posedge clk);
    model_edge(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
    #1;
    check("pre_reset_rdata", bus.sram_rdata, 32'h0000_1234);
    #1;
    reset = 1'b1;
    #1;
    m_led = 16'h0; m_timer = 32'h0; m_rd = 32'h0;
    check("midreset_rdata", bus.sram_rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    bus.sram_en = 1'b0;
    reset = 1'b0;
    cyc("post_tmr0", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("post_tmr0_const", bus.sram_rdata, 32'h0);
    cyc("post_tmr1", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("post_tmr1_const", bus.sram_rdata, 32'h1);
    cyc("post_tmr2", 1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("post_tmr2_const", bus.sram_rdata, 32'h2);
    cyc("post_ram", 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("post_ram_const", bus.sram_rdata, 32'h12BB_56DD);

    for (int i = 0; i < 8; i++) pool[i] = 14'($urandom);
    pool[0] = 14'h0000;
    pool[1] = 14'h3FFF;

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        switch_in = 8'($urandom);
        m_sw      = switch_in;
        idle("rnd_sw1");
        idle("rnd_sw2");
      end
      op = $urandom_range(0, 9);
      p  = $urandom_range(0, 7);
      do up = 16'($urandom); while (up == 16'hbfaf);
      a  = {up, pool[p], 2'b00};
      wd = $urandom;
      we = 4'($urandom_range(1, 15));
      case (op)
        0, 1, 2: begin
          if (!ram_m.exists(ram_idx(a))) we = 4'hF;
          cyc("rnd_ram_wr", 1'b1, we, a, wd);
        end
        3, 4, 5: begin
          if (ram_m.exists(ram_idx(a))) cyc("rnd_ram_rd", 1'b1, 4'h0, a, 32'h0);
          else idle("rnd_idle");
        end
        6: cyc("rnd_led_wr", 1'b1, we, 32'hbfaf_f000, wd);
        7: cyc("rnd_mmio_rd", 1'b1, 4'h0, {16'hbfaf, mmio_offs[$urandom_range(0, 4)]}, 32'h0);
        8: cyc("rnd_tmr_wr", 1'b1, we, 32'hbfaf_e000, wd);
        default: cyc("rnd_en0", 1'b0, we, a, wd);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
